dpr_op_sequencer: RTL and testbench

- Command sequencer in front of the reconfigurable arithmetic datapath (ADD/DEC/DIV/INC/MOD/MUL/MUX/REG/SHL/SHR/SUB RMs plus comparator).
- Accepts one operation at a time over valid/ready and drives op_sel, operands and mux_sel.
- Waits the op's settle latency, captures result and comparator flags, and returns them over valid/ready.
- Quiesces the datapath on a partial-reconfiguration request and acknowledges it, so RMs can be swapped without corrupting an in-flight op.

---
 rtl/dpr_seq_pkg.sv | 31 +++
 rtl/dpr_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_dpr_op_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dpr_seq_pkg.sv
// Shared definitions for the DPR op sequencer: datapath op codes, FSM state
// encoding and the per-op settle latency helper.
package dpr_seq_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_DEC = 1;
  localparam int OP_DIV = 2;
  localparam int OP_INC = 3;
  localparam int OP_MOD = 4;
  localparam int OP_MUL = 5;
  localparam int OP_MUX = 6;
  localparam int OP_REG = 7;
  localparam int OP_SHL = 8;
  localparam int OP_SHR = 9;
  localparam int OP_SUB = 10;

  localparam int NUM_OPS = 11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_RESP      = 2'd2,
    ST_DECOUPLED = 2'd3
  } state_e;

  // The REG module adds a pipeline stage, so it settles later than the combinational RMs.
  function automatic int op_latency(input int op, input int lat_comb, input int lat_reg);
    return (op == OP_REG) ? lat_reg : lat_comb;
  endfunction

endpackage

// File: rtl/dpr_op_sequencer.sv
// Issues one op at a time to the reconfigurable datapath, waits its settle
// latency, returns the captured result, and quiesces the datapath for reconfiguration.
module dpr_op_sequencer #(
  parameter int DATAWIDTH = 16,
  parameter int OPWIDTH   = 5,
  parameter int NUM_OPS   = dpr_seq_pkg::NUM_OPS,
  parameter int LAT_COMB  = 2,
  parameter int LAT_REG   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPWIDTH-1:0]   cmd_op,
  input  logic [DATAWIDTH-1:0] cmd_a,
  input  logic [DATAWIDTH-1:0] cmd_b,
  input  logic                 cmd_mux_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 rsp_lt,
  output logic                 rsp_gt,
  output logic                 rsp_eq,
  output logic [OPWIDTH-1:0]   dp_op_sel,
  output logic [DATAWIDTH-1:0] dp_a,
  output logic [DATAWIDTH-1:0] dp_b,
  output logic                 dp_mux_sel,
  input  logic [DATAWIDTH-1:0] dp_out,
  input  logic                 dp_lt,
  input  logic                 dp_gt,
  input  logic                 dp_eq,
  output logic                 dp_isolate,
  input  logic                 rcfg_req,
  output logic                 rcfg_ack,
  output logic                 busy
);
  import dpr_seq_pkg::*;

  localparam int LAT_MAX = (LAT_COMB > LAT_REG) ? LAT_COMB : LAT_REG;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  state_e               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 live_reg;
  logic [OPWIDTH-1:0]   op_next;
  logic [DATAWIDTH-1:0] a_next, b_next, data_next;
  logic                 mux_next, valid_next, err_next, lt_next, gt_next, eq_next;
  logic                 accept, op_legal;

  // live_reg keeps cmd_ready low while reset is asserted, even though state is IDLE.
  assign cmd_ready = live_reg && (state_reg == ST_IDLE) && !rcfg_req;
  assign accept    = cmd_valid && cmd_ready;
  assign op_legal  = int'(cmd_op) < NUM_OPS;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = dp_op_sel;
    a_next     = dp_a;
    b_next     = dp_b;
    mux_next   = dp_mux_sel;
    valid_next = rsp_valid;
    data_next  = rsp_data;
    err_next   = rsp_err;
    lt_next    = rsp_lt;
    gt_next    = rsp_gt;
    eq_next    = rsp_eq;

    case (state_reg)
      ST_IDLE: begin
        if (rcfg_req) begin
          state_next = ST_DECOUPLED;
        end else if (accept) begin
          if (op_legal) begin
            op_next    = cmd_op;
            a_next     = cmd_a;
            b_next     = cmd_b;
            mux_next   = cmd_mux_sel;
            cnt_next   = CNT_W'(op_latency(int'(cmd_op), LAT_COMB, LAT_REG));
            state_next = ST_EXEC;
          end else begin
            // Illegal codes never reach the datapath; answer immediately with an error.
            valid_next = 1'b1;
            data_next  = '0;
            err_next   = 1'b1;
            lt_next    = 1'b0;
            gt_next    = 1'b0;
            eq_next    = 1'b0;
            state_next = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_reg == CNT_W'(1)) begin
          valid_next = 1'b1;
          data_next  = dp_out;
          err_next   = 1'b0;
          lt_next    = dp_lt;
          gt_next    = dp_gt;
          eq_next    = dp_eq;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          valid_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_DECOUPLED: begin
        if (!rcfg_req) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      live_reg   <= 1'b0;
      dp_op_sel  <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
      dp_mux_sel <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rsp_lt     <= 1'b0;
      rsp_gt     <= 1'b0;
      rsp_eq     <= 1'b0;
      busy       <= 1'b0;
      rcfg_ack   <= 1'b0;
      dp_isolate <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      live_reg   <= 1'b1;
      dp_op_sel  <= op_next;
      dp_a       <= a_next;
      dp_b       <= b_next;
      dp_mux_sel <= mux_next;
      rsp_valid  <= valid_next;
      rsp_data   <= data_next;
      rsp_err    <= err_next;
      rsp_lt     <= lt_next;
      rsp_gt     <= gt_next;
      rsp_eq     <= eq_next;
      busy       <= (state_next != ST_IDLE);
      rcfg_ack   <= (state_next == ST_DECOUPLED);
      dp_isolate <= (state_next == ST_DECOUPLED);
    end
  end

endmodule

// File: tb/tb_dpr_op_sequencer.sv
// Directed plus randomized checks of dpr_op_sequencer against a behavioural
// datapath and a transaction-level reference model.
module tb_dpr_op_sequencer;
  import dpr_seq_pkg::*;

  localparam int DW = 16;
  localparam int OW = 5;
  localparam int L_COMB = 2;
  localparam int L_REG = 3;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_mux_sel;
  logic [OW-1:0] cmd_op;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_lt, rsp_gt, rsp_eq;
  logic [DW-1:0] rsp_data;
  logic [OW-1:0] dp_op_sel;
  logic [DW-1:0] dp_a, dp_b, dp_out;
  logic          dp_mux_sel, dp_lt, dp_gt, dp_eq, dp_isolate;
  logic          rcfg_req, rcfg_ack, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [OW-1:0] exp_op;
  logic [DW-1:0] exp_a, exp_b;
  logic          exp_mux;
  logic [DW-1:0] reg_q;

  dpr_op_sequencer #(
    .DATAWIDTH(DW), .OPWIDTH(OW), .NUM_OPS(NUM_OPS), .LAT_COMB(L_COMB), .LAT_REG(L_REG)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mux_sel(cmd_mux_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_lt(rsp_lt), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq),
    .dp_op_sel(dp_op_sel), .dp_a(dp_a), .dp_b(dp_b), .dp_mux_sel(dp_mux_sel),
    .dp_out(dp_out), .dp_lt(dp_lt), .dp_gt(dp_gt), .dp_eq(dp_eq),
    .dp_isolate(dp_isolate), .rcfg_req(rcfg_req), .rcfg_ack(rcfg_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_calc(input int op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic mux);
    logic [DW-1:0] r;
    case (op)
      OP_ADD:         r = a + b;
      OP_DEC:         r = a - 16'd1;
      OP_DIV:         r = (b == 0) ? '0 : a / b;
      OP_INC:         r = a + 16'd1;
      OP_MOD:         r = (b == 0) ? '0 : a % b;
      OP_MUL:         r = a * b;
      OP_MUX, OP_REG: r = mux ? b : a;
      OP_SHL:         r = a << b[3:0];
      OP_SHR:         r = a >> b[3:0];
      OP_SUB:         r = a - b;
      default:        r = '0;
    endcase
    return r;
  endfunction

  // Behavioural datapath: the REG module is one flop behind its inputs; isolation forces 0.
  always @(posedge clk) reg_q <= dp_mux_sel ? dp_b : dp_a;
  assign dp_out = dp_isolate ? '0 :
                  (int'(dp_op_sel) == OP_REG) ? reg_q :
                  ref_calc(int'(dp_op_sel), dp_a, dp_b, dp_mux_sel);
  assign dp_lt = !dp_isolate && (dp_a < dp_b);
  assign dp_gt = !dp_isolate && (dp_a > dp_b);
  assign dp_eq = !dp_isolate && (dp_a == dp_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic mux, input int stall);
    logic legal;
    int lat, n;
    logic [DW-1:0] e_data;
    logic e_lt, e_gt, e_eq;
    legal = (op < NUM_OPS);
    if (legal) begin
      exp_op = 5'(op); exp_a = a; exp_b = b; exp_mux = mux;
      lat = (op == OP_REG) ? L_REG : L_COMB;
      e_data = ref_calc(op, a, b, mux);
      e_lt = a < b; e_gt = a > b; e_eq = a == b;
    end else begin
      lat = 0; e_data = '0; e_lt = 0; e_gt = 0; e_eq = 0;
    end
    cmd_valid = 1'b1; cmd_op = 5'(op); cmd_a = a; cmd_b = b; cmd_mux_sel = mux;
    rsp_ready = (stall == 0);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("dp_op_sel", 32'(dp_op_sel), 32'(exp_op));
    check("dp_a", 32'(dp_a), 32'(exp_a));
    check("dp_b", 32'(dp_b), 32'(exp_b));
    check("dp_mux_sel", 32'(dp_mux_sel), 32'(exp_mux));
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 16) begin
      check("cmd_ready_exec", 32'(cmd_ready), 32'd0);
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'(e_data));
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(e_data));
    check("rsp_err", 32'(rsp_err), 32'(!legal));
    check("rsp_flags", 32'({rsp_lt, rsp_gt, rsp_eq}), 32'({e_lt, e_gt, e_eq}));
    check("busy_resp", 32'(busy), 32'd1);
    tick();
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("cmd_ready_again", 32'(cmd_ready), 32'd1);
    $display("op=%0d a=%h b=%h mux=%b stall=%0d lat=%0d data=%h err=%b flags=%b%b%b",
             op, a, b, mux, stall, n, rsp_data, rsp_err, rsp_lt, rsp_gt, rsp_eq);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_err, rsp_lt, rsp_gt, rsp_eq}), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_dp_op"}, 32'({dp_op_sel, dp_mux_sel}), 32'd0);
    check({tag, "_dp_ab"}, {dp_a, dp_b}, 32'd0);
    check({tag, "_ctl"}, 32'({dp_isolate, rcfg_ack, busy}), 32'd0);
  endtask

  initial begin
    int n, op, stall;
    logic [DW-1:0] a, b;
    rst = 1'b0; cmd_valid = 0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_mux_sel = 0;
    rsp_ready = 0; rcfg_req = 0;
    exp_op = '0; exp_a = '0; exp_b = '0; exp_mux = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    #2 rst = 1'b1;
    tick(); tick();
    check("cmd_ready_post_reset", 32'(cmd_ready), 32'd1);

    do_op(0, 16'd3, 16'd5, 1'b0, 0);
    do_op(7, 16'h00AA, 16'h1234, 1'b0, 0);
    do_op(12, 16'h5555, 16'h0001, 1'b1, 0);
    do_op(5, 16'd6, 16'd7, 1'b0, 5);
    do_op(7, 16'h0F0F, 16'h7777, 1'b1, 1);

    // Reconfiguration requested mid-EXEC: the op still completes first.
    cmd_valid = 1; cmd_op = 5'd10; cmd_a = 16'd9; cmd_b = 16'd4; cmd_mux_sel = 0;
    rsp_ready = 1;
    tick();
    cmd_valid = 0;
    exp_op = 5'd10; exp_a = 16'd9; exp_b = 16'd4; exp_mux = 1'b0;
    tick();
    rcfg_req = 1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 16) begin tick(); n++; end
    check("rcfg_latency", 32'(n), 32'd1);
    check("rcfg_rsp_data", 32'(rsp_data), 32'd5);
    check("rcfg_rsp_flags", 32'({rsp_err, rsp_lt, rsp_gt, rsp_eq}), 32'b0010);
    tick();
    check("rcfg_rsp_drop", 32'(rsp_valid), 32'd0);
    check("rcfg_idle_no_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1; cmd_op = 5'd0; cmd_a = 16'd1; cmd_b = 16'd1;
    tick();
    check("decoupled_ack", 32'({rcfg_ack, dp_isolate, busy}), 32'b111);
    check("decoupled_no_ready", 32'(cmd_ready), 32'd0);
    check("decoupled_dp_hold", 32'(dp_op_sel), 32'(exp_op));
    tick(); tick();
    check("decoupled_ack_hold", 32'({rcfg_ack, dp_isolate}), 32'b11);
    check("decoupled_no_rsp", 32'(rsp_valid), 32'd0);
    check("decoupled_dp_a_hold", 32'(dp_a), 32'(exp_a));
    rcfg_req = 0; cmd_valid = 0;
    check("decoupled_exit_no_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("recoupled_ack", 32'({rcfg_ack, dp_isolate, busy}), 32'b000);
    check("recoupled_ready", 32'(cmd_ready), 32'd1);
    $display("rcfg sequence: op=10 a=9 b=4 delivered, decoupled and released");

    // Asynchronous reset in the middle of EXEC.
    cmd_valid = 1; cmd_op = 5'd5; cmd_a = 16'd6; cmd_b = 16'd7;
    tick();
    cmd_valid = 0;
    tick();
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    #2 rst = 1'b1;
    exp_op = '0; exp_a = '0; exp_b = '0; exp_mux = 1'b0;
    tick(); tick();
    check("post_async_ready", 32'(cmd_ready), 32'd1);
    check("post_async_no_rsp", 32'({rsp_valid, busy}), 32'd0);
    $display("async reset mid-EXEC: outputs cleared, no stale response");

    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 13));
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      stall = int'($urandom_range(0, 2));
      do_op(op, a, b, 1'($urandom_range(0, 1)), stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
